// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions raw board pushbuttons for the game logic in the
//               clk25 domain. Each channel has a 2-flop synchroniser, a
//               counter-based debounce FSM, one-cycle press/release strobes
//               and a hold-to-repeat strobe used for paddle movement.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1        pixel-domain clock (clk25)
//   rst_n          in   1        asynchronous active-low reset
//   btn_raw_i      in   NUM_BTN  raw asynchronous pushbuttons, active high
//   btn_level_o    out  NUM_BTN  debounced button level
//   btn_press_o    out  NUM_BTN  1-cycle strobe on debounced rising edge
//   btn_release_o  out  NUM_BTN  1-cycle strobe on debounced falling edge
//   btn_repeat_o   out  NUM_BTN  strobe on press, then auto-repeat while held
// ============================================================================
module button_conditioner #(
  parameter int NUM_BTN       = 4,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 6250000,
  parameter int REPEAT_PERIOD = 625000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic [NUM_BTN-1:0] btn_repeat_o
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RMAX + 1);

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]  DEB_SAT   = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [RCNT_W-1:0] RDLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPER_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] RCNT_SAT  = RCNT_W'(RMAX);
  localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HELD   = 2'd2,
    ST_CHK_LO = 2'd3
  } state_e;

  // Two-flop synchroniser; only s2_q is used by the channel logic.
  logic [NUM_BTN-1:0] s1_q;
  logic [NUM_BTN-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw_i;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              rphase_q, rphase_d;   // 0: waiting initial delay, 1: periodic
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;
    logic              w_s2;
    logic              w_rep_hit;

    assign w_s2 = s2_q[i];

    // Debounce FSM next-state and edge strobes.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (w_s2) begin
            state_d = ST_CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
        ST_CHK_HI: begin
          if (!w_s2) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else if (cnt_q != DEB_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!w_s2) begin
            state_d = ST_CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
        ST_CHK_LO: begin
          if (w_s2) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q != DEB_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
      level_d = (state_d == ST_HELD) || (state_d == ST_CHK_LO);
    end

    // The terminal count depends on whether the first repeat has fired yet.
    assign w_rep_hit = rphase_q ? (rcnt_q == RPER_LAST) : (rcnt_q == RDLY_LAST);

    // Auto-repeat: strobe on press, then after the delay, then periodically.
    // Leaving the held region (release) clears the counter without a strobe.
    always_comb begin
      rcnt_d   = rcnt_q;
      rphase_d = rphase_q;
      repeat_d = 1'b0;
      if (press_d) begin
        rcnt_d   = '0;
        rphase_d = 1'b0;
        repeat_d = 1'b1;
      end else if (level_d) begin
        if (w_rep_hit) begin
          rcnt_d   = '0;
          rphase_d = 1'b1;
          repeat_d = 1'b1;
        end else if (rcnt_q != RCNT_SAT) begin
          rcnt_d = rcnt_q + RCNT_ONE;
        end
      end else begin
        rcnt_d   = '0;
        rphase_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        rcnt_q    <= '0;
        rphase_q  <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        rcnt_q    <= rcnt_d;
        rphase_q  <= rphase_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    assign btn_level_o[i]   = level_q;
    assign btn_press_o[i]   = press_q;
    assign btn_release_o[i] = release_q;
    assign btn_repeat_o[i]  = repeat_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int NUM_BTN = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  int checks;
  int failures;

  button_conditioner #(
    .NUM_BTN      (NUM_BTN),
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw_i    (btn_raw),
    .btn_level_o  (btn_level),
    .btn_press_o  (btn_press),
    .btn_release_o(btn_release),
    .btn_repeat_o (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_p, exp_l, exp_r;
    rst_n   = 1'b0;
    btn_raw = 4'b1111;
    tick(3);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs actual=%h expected=0000",
               {btn_level, btn_press, btn_release, btn_repeat});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      exp_p = (e == 6) ? 4'b1111 : 4'b0000;
      exp_l = (e >= 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (btn_press !== exp_p) begin
        failures++;
        $display("FAIL reset_press edge=%0d actual=%b expected=%b", e, btn_press, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        failures++;
        $display("FAIL reset_level edge=%0d actual=%b expected=%b", e, btn_level, exp_l);
      end
      checks++;
      if (btn_repeat !== exp_p) begin
        failures++;
        $display("FAIL reset_repeat edge=%0d actual=%b expected=%b", e, btn_repeat, exp_p);
      end
    end
    btn_raw = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      exp_r = (e == 6) ? 4'b1111 : 4'b0000;
      exp_l = (e >= 6) ? 4'b0000 : 4'b1111;
      checks++;
      if (btn_release !== exp_r) begin
        failures++;
        $display("FAIL reset_release edge=%0d actual=%b expected=%b", e, btn_release, exp_r);
      end
      checks++;
      if (btn_level !== exp_l) begin
        failures++;
        $display("FAIL reset_rel_level edge=%0d actual=%b expected=%b", e, btn_level, exp_l);
      end
      checks++;
      if (btn_repeat !== 4'b0000) begin
        failures++;
        $display("FAIL reset_rel_repeat edge=%0d actual=%b expected=0000", e, btn_repeat);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_p;
    for (int b = 0; b < 4; b++) begin
      btn_raw[0] = (b % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
      checks++;
      if ({btn_level, btn_press, btn_repeat} !== 12'h000) begin
        failures++;
        $display("FAIL bounce_quiet step=%0d actual=%h expected=000", b,
                 {btn_level, btn_press, btn_repeat});
      end
    end
    btn_raw[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      exp_p = (e == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_press !== exp_p) begin
        failures++;
        $display("FAIL bounce_press edge=%0d actual=%b expected=%b", e, btn_press, exp_p);
      end
    end
    btn_raw[0] = 1'b0;
    tick(8);
    checks++;
    if (btn_level !== 4'b0000) begin
      failures++;
      $display("FAIL bounce_idle actual=%b expected=0000", btn_level);
    end
  endtask

  task automatic test_glitch();
    btn_raw[2] = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick(1);
      if (e == 3) btn_raw[2] = 1'b0;
      checks++;
      if ({btn_level[2], btn_press[2], btn_repeat[2]} !== 3'b000) begin
        failures++;
        $display("FAIL glitch edge=%0d actual=%b expected=000", e,
                 {btn_level[2], btn_press[2], btn_repeat[2]});
      end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] exp_v;
    logic       rep_e;
    btn_raw[1] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      exp_v = (e == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_press !== exp_v) begin
        failures++;
        $display("FAIL repeat_press edge=%0d actual=%b expected=%b", e, btn_press, exp_v);
      end
    end
    // k counts edges after the press edge; raw drops after k=30, release at k=36.
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 30) btn_raw[1] = 1'b0;
      rep_e = (k >= 10) && (k < 36) && (((k - 10) % 3) == 0);
      exp_v = {2'b00, rep_e, 1'b0};
      checks++;
      if (btn_repeat !== exp_v) begin
        failures++;
        $display("FAIL repeat_strobe k=%0d actual=%b expected=%b", k, btn_repeat, exp_v);
      end
      exp_v = (k == 36) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_release !== exp_v) begin
        failures++;
        $display("FAIL repeat_release k=%0d actual=%b expected=%b", k, btn_release, exp_v);
      end
      exp_v = (k < 36) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_level !== exp_v) begin
        failures++;
        $display("FAIL repeat_level k=%0d actual=%b expected=%b", k, btn_level, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_p;
    btn_raw = 4'b1001;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      exp_p = (e == 6) ? 4'b1001 : 4'b0000;
      checks++;
      if (btn_press !== exp_p) begin
        failures++;
        $display("FAIL simul_press edge=%0d actual=%b expected=%b", e, btn_press, exp_p);
      end
    end
    checks++;
    if (btn_level !== 4'b1001) begin
      failures++;
      $display("FAIL simul_level actual=%b expected=1001", btn_level);
    end
  endtask

  task automatic test_async_reset();
    // Buttons 0 and 3 are still held from the previous scenario.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset_immediate actual=%h expected=0000",
               {btn_level, btn_press, btn_release, btn_repeat});
    end
    btn_raw = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== 16'h0000) begin
        failures++;
        $display("FAIL async_reset_no_release edge=%0d actual=%h expected=0000", e,
                 {btn_level, btn_press, btn_release, btn_repeat});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    btn_raw  = '0;
    test_reset();
    test_bounce();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
